// File: rtl/divider_16bit_pkg.sv
// Shared types and constants for the 16-bit restoring divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] PREC_8BIT = 2'b00;
  localparam logic [4:0] ITER_16   = 5'd16;
  localparam logic [4:0] ITER_8    = 5'd8;

endpackage

// File: rtl/divider_16bit_if.sv
// Operand/result handshake bundle between the lane slice and the divider.
interface divider_16bit_if;

  logic        in_valid;
  logic        in_ready;
  logic [15:0] operand_a_16bit;
  logic [15:0] operand_b_16bit;
  logic [1:0]  precision;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] output_16bit_div;

  modport master (
    output in_valid, operand_a_16bit, operand_b_16bit, precision, out_ready,
    input  in_ready, out_valid, output_16bit_div
  );

  modport slave (
    input  in_valid, operand_a_16bit, operand_b_16bit, precision, out_ready,
    output in_ready, out_valid, output_16bit_div
  );

endinterface

// File: rtl/divider_16bit_step.sv
// One combinational restoring-division step of configurable width.
module restoring_div_step #(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic             i_dbit,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_rem,
  output logic             o_qbit
);

  logic [WIDTH:0] w_shift;
  logic [WIDTH:0] w_diff;

  // Shift in the next dividend bit, trial-subtract, restore on borrow.
  // A set top bit of the shifted value already guarantees it exceeds the divisor.
  always_comb begin
    w_shift = {i_rem, i_dbit};
    w_diff  = w_shift - {1'b0, i_divisor};
    o_qbit  = w_shift[WIDTH] | ~w_diff[WIDTH];
    o_rem   = o_qbit ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
  end

endmodule

// File: rtl/divider_16bit.sv
// Iterative unsigned restoring divider: one 16-bit divide or two 8-bit lanes.
module divider_16bit
  import div_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  divider_16bit_if.slave  bus
);

  state_t      r_state;
  state_t      w_next;
  logic        r_mode8;
  logic [4:0]  r_cnt;
  logic [15:0] r_a;
  logic [15:0] r_b;
  logic [15:0] r_rem;
  logic [15:0] r_q;
  logic [31:0] r_out;

  logic [15:0] w_rem16;
  logic        w_q16;
  logic [7:0]  w_rem1;
  logic [7:0]  w_rem0;
  logic        w_q1;
  logic        w_q0;
  logic [15:0] w_rem_next;
  logic [15:0] w_q_next;
  logic [15:0] w_a_next;
  logic [4:0]  w_term;
  logic        w_last;

  restoring_div_step #(.WIDTH(16)) u_step16 (
    .i_rem     (r_rem),
    .i_dbit    (r_a[15]),
    .i_divisor (r_b),
    .o_rem     (w_rem16),
    .o_qbit    (w_q16)
  );

  restoring_div_step #(.WIDTH(8)) u_step_lane1 (
    .i_rem     (r_rem[15:8]),
    .i_dbit    (r_a[15]),
    .i_divisor (r_b[15:8]),
    .o_rem     (w_rem1),
    .o_qbit    (w_q1)
  );

  restoring_div_step #(.WIDTH(8)) u_step_lane0 (
    .i_rem     (r_rem[7:0]),
    .i_dbit    (r_a[7]),
    .i_divisor (r_b[7:0]),
    .o_rem     (w_rem0),
    .o_qbit    (w_q0)
  );

  // Select the step results for the latched mode; lanes shift independently at bit 8.
  always_comb begin
    w_term = r_mode8 ? ITER_8 : ITER_16;
    w_last = (r_cnt == (w_term - 5'd1));
    if (r_mode8) begin
      w_rem_next = {w_rem1, w_rem0};
      w_q_next   = {r_q[14:8], w_q1, r_q[6:0], w_q0};
      w_a_next   = {r_a[14:8], 1'b0, r_a[6:0], 1'b0};
    end else begin
      w_rem_next = w_rem16;
      w_q_next   = {r_q[14:0], w_q16};
      w_a_next   = {r_a[14:0], 1'b0};
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  // Next-state decode and handshake outputs.
  always_comb begin
    w_next               = r_state;
    bus.in_ready         = 1'b0;
    bus.out_valid        = 1'b0;
    bus.output_16bit_div = r_out;
    case (r_state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) w_next = CALC;
      end
      CALC: begin
        if (w_last) w_next = DONE;
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Operand latch, per-cycle iteration and result capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mode8 <= 1'b0;
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_rem   <= '0;
      r_q     <= '0;
      r_out   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_a     <= bus.operand_a_16bit;
            r_b     <= bus.operand_b_16bit;
            r_mode8 <= (bus.precision == PREC_8BIT);
            r_rem   <= '0;
            r_q     <= '0;
            r_cnt   <= '0;
          end
        end
        CALC: begin
          r_a   <= w_a_next;
          r_rem <= w_rem_next;
          r_q   <= w_q_next;
          if (r_cnt < w_term) r_cnt <= r_cnt + 5'd1;
          if (w_last) r_out <= {w_rem_next, w_q_next};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_divider_16bit.sv
// Self-checking bench for divider_16bit: vector table, random ops, corner sequences.
module tb_divider_16bit;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  divider_16bit_if bus ();

  divider_16bit dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [1:0]  prec;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Plain-arithmetic reference: per-lane / and %, divide-by-zero gives all-ones quotient.
  function automatic logic [31:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic [1:0] p);
    logic [7:0]  a1, a0, b1, b0, q1, q0, r1, r0;
    logic [15:0] q, r;
    if (p == 2'b00) begin
      a1 = a[15:8]; a0 = a[7:0]; b1 = b[15:8]; b0 = b[7:0];
      q1 = (b1 == 0) ? 8'hFF : a1 / b1;
      r1 = (b1 == 0) ? a1    : a1 % b1;
      q0 = (b0 == 0) ? 8'hFF : a0 / b0;
      r0 = (b0 == 0) ? a0    : a0 % b0;
      return {r1, r0, q1, q0};
    end
    q = (b == 0) ? 16'hFFFF : a / b;
    r = (b == 0) ? a        : a % b;
    return {r, q};
  endfunction

  task automatic wait_ready();
    int guard;
    guard = 0;
    while (!bus.in_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!bus.in_ready) chk("wait_in_ready", 32'(bus.in_ready), 32'd1);
  endtask

  // Accept one op, optionally disturb inputs / pre-assert out_ready, collect result.
  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic [1:0] p,
                       input bit scramble, input bit early_rdy,
                       output logic [31:0] res, output int lat);
    int ready_seen;
    wait_ready();
    bus.in_valid        = 1'b1;
    bus.operand_a_16bit = a;
    bus.operand_b_16bit = b;
    bus.precision       = p;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    if (scramble) begin
      bus.operand_a_16bit = 16'($urandom);
      bus.operand_b_16bit = 16'($urandom);
      bus.precision       = ~p;
    end
    if (early_rdy) bus.out_ready = 1'b1;
    lat        = 0;
    ready_seen = 0;
    while (!bus.out_valid && lat < 40) begin
      if (bus.in_ready) ready_seen++;
      bus.in_valid = scramble ? 1'b1 : 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    bus.in_valid = 1'b0;
    chk("in_ready_low_busy", 32'(ready_seen), 32'd0);
    res = bus.output_16bit_div;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("handoff_ready_valid", {30'd0, bus.in_ready, bus.out_valid}, 32'b10);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] res, exp;
    logic [15:0] ra, rb;
    logic [1:0]  rp;
    int          lat;
    int          wguard;

    checks = 0;
    errors = 0;

    vecs[0] = '{16'h03E8, 16'h0007, 2'b01, 32'h0006_008E};
    vecs[1] = '{16'hC864, 16'h0B03, 2'b00, 32'h0201_1221};
    vecs[2] = '{16'h1234, 16'h0000, 2'b10, 32'h1234_FFFF};
    vecs[3] = '{16'h500A, 16'h0002, 2'b00, 32'h5000_FF05};
    vecs[4] = '{16'hFFFF, 16'h0001, 2'b11, 32'h0000_FFFF};
    vecs[5] = '{16'h0000, 16'h0005, 2'b01, 32'h0000_0000};
    vecs[6] = '{16'h0005, 16'hFFFF, 2'b10, 32'h0005_0000};
    vecs[7] = '{16'hFFFF, 16'hFFFF, 2'b00, 32'h0000_0101};
    vecs[8] = '{16'h07FE, 16'h0310, 2'b00, 32'h010E_020F};

    bus.in_valid        = 1'b0;
    bus.out_ready       = 1'b0;
    bus.operand_a_16bit = '0;
    bus.operand_b_16bit = '0;
    bus.precision       = 2'b01;
    rst_n               = 1'b0;

    #12;
    chk("reset_in_ready", 32'(bus.in_ready), 32'd1);
    chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset_output", bus.output_16bit_div, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_reset_in_ready", 32'(bus.in_ready), 32'd1);

    // Directed vector table.
    for (int i = 0; i < 9; i++) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].prec, 1'b0, 1'b0, res, lat);
      chk($sformatf("vec%0d_result", i), res, vecs[i].exp);
      chk($sformatf("vec%0d_latency", i), 32'(lat), (vecs[i].prec == 2'b00) ? 32'd8 : 32'd16);
    end

    // Randomized ops against the reference model, some with disturbed inputs.
    for (int i = 0; i < 40; i++) begin
      ra = 16'($urandom);
      rb = ($urandom_range(0, 5) == 0) ? 16'h0000 : 16'($urandom);
      if ($urandom_range(0, 3) == 0) rb[7:0] = 8'h00;
      rp = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
      exp = model(ra, rb, rp);
      do_op(ra, rb, rp, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), res, lat);
      chk($sformatf("rand%0d_result", i), res, exp);
      chk($sformatf("rand%0d_latency", i), 32'(lat), (rp == 2'b00) ? 32'd8 : 32'd16);
    end

    // Operand/precision change right after accept must not affect the result.
    do_op(16'hC864, 16'h0B03, 2'b00, 1'b1, 1'b0, res, lat);
    chk("scramble_8bit_result", res, 32'h0201_1221);
    do_op(16'h03E8, 16'h0007, 2'b11, 1'b1, 1'b0, res, lat);
    chk("scramble_16bit_result", res, 32'h0006_008E);

    // Backpressure: result holds while out_ready stays low, in_valid toggling.
    wait_ready();
    bus.in_valid = 1'b1; bus.operand_a_16bit = 16'hABCD;
    bus.operand_b_16bit = 16'h0013; bus.precision = 2'b01;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    wguard = 0;
    while (!bus.out_valid && wguard < 40) begin
      @(posedge clk); #1;
      wguard++;
    end
    chk("bp_out_valid_rise", 32'(bus.out_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = (i % 2 == 0);
      bus.operand_a_16bit = 16'($urandom);
      @(posedge clk); #1;
      chk($sformatf("bp%0d_out_valid", i), 32'(bus.out_valid), 32'd1);
      chk($sformatf("bp%0d_result", i), bus.output_16bit_div, 32'h000F_090A);
      chk($sformatf("bp%0d_in_ready", i), 32'(bus.in_ready), 32'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("bp_release_in_ready", 32'(bus.in_ready), 32'd1);
    chk("bp_release_out_valid", 32'(bus.out_valid), 32'd0);
    @(posedge clk); #1;
    chk("bp_idle_hold", 32'(bus.in_ready), 32'd1);

    // Reset during CALC aborts the op and clears the result register.
    wait_ready();
    bus.in_valid = 1'b1; bus.operand_a_16bit = 16'h4321;
    bus.operand_b_16bit = 16'h0009; bus.precision = 2'b01;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midreset_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midreset_output", bus.output_16bit_div, 32'd0);
    chk("midreset_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("after_reset_in_ready", 32'(bus.in_ready), 32'd1);
    do_op(16'hFFFF, 16'h0001, 2'b01, 1'b0, 1'b0, res, lat);
    chk("after_reset_result", res, 32'h0000_FFFF);
    chk("after_reset_latency", 32'(lat), 32'd16);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/divider_16bit.md
Name: divider_16bit

Overview:
- Iterative unsigned restoring divider. It is the inverse-operation companion to the vector multiplier in the 32-bit vector datapath.
- Accepts a 16-bit dividend and divisor with the same precision control as the multiplier: 2'b00 selects two independent 8-bit lanes, any other value selects one 16-bit divide.
- Returns quotient and remainder over a valid/ready handshake. The block sits beside the multiplier inside the vector lane slice.

Parameters:
- none (widths are fixed at 16-bit operands and a 32-bit result, matching the multiplier lane)

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-low reset
- in_valid  input  1  operand pair valid
- in_ready  output  1  block can accept operands
- operand_a_16bit  input  16  dividend; in 8-bit mode lane1=[15:8], lane0=[7:0]
- operand_b_16bit  input  16  divisor; same lane split
- precision  input  2  2'b00 = 2x8-bit lanes, any other value = 1x16-bit
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- output_16bit_div  output  32  {remainder[15:0], quotient[15:0]}; in 8-bit mode quotient={q1,q0}, remainder={r1,r0}

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-low. While rst=0: state=IDLE, output_16bit_div=0, out_valid=0, all internal registers=0. in_ready reads 1 during reset and immediately after release.
- States:
  - IDLE: in_ready=1. On in_valid=1, latch operands and precision (precision==2'b00 gives 8-bit mode), clear partial remainders and the iteration counter, then go to CALC.
  - CALC: in_ready=0. Perform one restoring step per cycle: shift in the next dividend MSB, trial-subtract the divisor, set the quotient bit if the result is non-negative, otherwise restore.
    - 16-bit mode: 16 iterations.
    - 8-bit mode: 8 iterations, with both lanes stepping in parallel. No borrow or shift propagates across bit 8.
    - After the final iteration, load output_16bit_div and go to DONE.
  - DONE: out_valid=1. output_16bit_div is stable. If out_ready=1, go to IDLE and drop out_valid on the next edge.
- Latency: out_valid rises exactly N cycles after the accepting edge (N=16 for 16-bit, N=8 for 8-bit). Minimum spacing between accepts is N+2 cycles; there is no accept in the same cycle as a result handoff.
- Divide-by-zero (per lane in 8-bit mode): quotient = all ones of the lane width, remainder = dividend. Latency is unchanged and no flag is raised.
- Inputs sampled only on the accept edge. Changes to operands or precision during CALC/DONE have no effect.
- in_valid during CALC/DONE is ignored. in_ready=0 signals the upstream to hold.
- out_ready while out_valid=0 is ignored.
- Reset asserted mid-CALC or mid-DONE aborts the operation. The result is discarded and everything returns to the reset values above.
- The counter is 5 bits and saturates at the terminal count; it never wraps into a stray iteration.

Decomposition:
- Shared package div_pkg holds:
  - state typedef enum {IDLE, CALC, DONE}
  - PREC_8BIT = 2'b00
  - ITER_16 = 16, ITER_8 = 8
- Sub-module restoring_div_step #(WIDTH): combinational single step, taking partial remainder, dividend bit and divisor, and producing the next remainder and quotient bit.
- divider_16bit instantiates one WIDTH=16 and two WIDTH=8 copies. Precision selects which results update the registers.

Test Plan:
- 16-bit, a=0x03E8 (1000), b=0x0007: output_16bit_div=0x0006_008E, out_valid 16 cycles after accept.
- 8-bit (precision=00), a=0xC864, b=0x0B03: quotient=0x1221, remainder=0x0201, so output_16bit_div=0x0201_1221; out_valid 8 cycles after accept.
- Divide-by-zero:
  - 16-bit, a=0x1234, b=0 gives 0x1234_FFFF.
  - 8-bit, a=0x500A, b=0x0002 gives quotient 0xFF05, remainder 0x5000.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid with in_valid=1 toggling. Result and out_valid stay stable, in_ready=0 and no new accept; out_ready=1 leads to IDLE with in_ready=1 on the next cycle.
- Reset mid-CALC: pull rst low at iteration 5 of a 16-bit op. Immediately out_valid=0 and output_16bit_div=0; after release in_ready=1, and a fresh 0xFFFF/0x0001 gives 0x0000_FFFF.
- Operand change during CALC: change operand_a_16bit and precision after accept. The result reflects only the latched values and mode.
